// File: rtl/dmem_access_ctrl_if.sv
// Data-side SRAM-like bus between the MEM-stage access controller and the
// data cache / bus bridge. The master issues req with address/control and
// the slave answers with addr_ok (request accepted) then data_ok (done).
interface dmem_access_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data memory access sequencer. Turns one valid load/store into
// exactly one bus transaction, stalls the pipeline until it completes, and
// keeps the returned word stable until the MEM stage advances. A flush that
// lands mid-transaction cannot withdraw the request, so the response is
// absorbed silently via the drop flag.
module dmem_access_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                mem_en,
    input  logic [3:0]          mem_wen,
    input  logic [1:0]          mem_size,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_excpt,
    input  logic                flush,
    input  logic                pipe_stall,
    dmem_access_ctrl_if.master  bus,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                dmem_stall
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t            state_r;
    logic              drop_r;
    logic              req_r;
    logic              wr_r;
    logic [1:0]        size_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] rdata_r;
    logic              start_s;
    logic              drop_s;
    logic              stall_s;

    // Start condition, effective drop (a flush coinciding with data_ok also
    // discards the response) and pipeline stall request.
    always_comb begin
        start_s = 1'b0;
        drop_s  = drop_r | flush;
        stall_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                start_s = mem_en & ~mem_excpt & ~flush;
                stall_s = start_s;
            end
            ST_ADDR: stall_s = 1'b1;
            ST_DATA: stall_s = 1'b1;
            ST_HOLD: stall_s = 1'b0;
            default: stall_s = 1'b0;
        endcase
    end

    // Transaction sequencer: state, drop flag, captured bus fields, read word.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            drop_r  <= 1'b0;
            req_r   <= 1'b0;
            wr_r    <= 1'b0;
            size_r  <= 2'd0;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            rdata_r <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    drop_r <= 1'b0;
                    if (start_s) begin
                        wr_r    <= |mem_wen;
                        size_r  <= mem_size;
                        addr_r  <= mem_addr;
                        wdata_r <= mem_wdata;
                        req_r   <= 1'b1;
                        state_r <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    // The request stays up until accepted even when flushed.
                    if (flush) begin
                        drop_r <= 1'b1;
                    end
                    if (bus.data_addr_ok) begin
                        req_r   <= 1'b0;
                        state_r <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bus.data_data_ok) begin
                        drop_r <= 1'b0;
                        if (drop_s) begin
                            state_r <= ST_IDLE;
                        end else begin
                            if (!wr_r) begin
                                rdata_r <= bus.data_rdata;
                            end
                            state_r <= ST_HOLD;
                        end
                    end else if (flush) begin
                        drop_r <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    // Leave only when the MEM stage really advances (or is flushed),
                    // so a held instruction is never issued twice.
                    if (flush || !pipe_stall) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    drop_r  <= 1'b0;
                    req_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_req   = req_r;
    assign bus.data_wr    = wr_r;
    assign bus.data_size  = size_r;
    assign bus.data_addr  = addr_r;
    assign bus.data_wdata = wdata_r;
    assign mem_rdata      = rdata_r;
    assign dmem_stall     = stall_s;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios followed by
// randomized accesses with random bus latencies, hold lengths and flushes.
// Expectations come from transaction-level rules: one request per access,
// request lasting until acceptance, stall length = 3 + bus wait cycles,
// read word updated only by non-flushed loads.
module tb_dmem_access_ctrl;

    logic        clk;
    logic        resetn;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_excpt;
    logic        flush;
    logic        pipe_stall;
    logic [31:0] mem_rdata;
    logic        dmem_stall;

    int          n_pass;
    int          n_total;
    logic [31:0] exp_rdata;

    dmem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .mem_en     (mem_en),
        .mem_wen    (mem_wen),
        .mem_size   (mem_size),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_excpt  (mem_excpt),
        .flush      (flush),
        .pipe_stall (pipe_stall),
        .bus        (bus),
        .mem_rdata  (mem_rdata),
        .dmem_stall (dmem_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One cycle with nothing presented to the controller; it must be idle.
    task automatic idle_cycle();
        mem_en = 1'b0;
        flush  = 1'b0;
        @(negedge clk);
        chk("idle_stall", {31'd0, dmem_stall}, 32'd0);
        chk("idle_req", {31'd0, bus.data_req}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // One memory instruction from MEM-stage entry to MEM-stage exit.
    // a_lat: extra req cycles before addr_ok; d_lat: extra DATA cycles before
    // data_ok; hold_cyc: pipe_stall cycles in HOLD; flush_at: 0 none,
    // 1 first request cycle, 2 first data-wait cycle. Entered at posedge+1
    // and returns at posedge+1 on the cycle after the instruction leaves.
    task automatic do_access(input logic [3:0] wen, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int a_lat,
                             input int d_lat, input int hold_cyc, input int flush_at);
        int req_cyc = 0;
        int stall_cyc = 0;
        int dwait = 0;
        int hold_n = 0;
        bit addr_done = 1'b0;
        bit resp_done = 1'b0;
        bit done = 1'b0;
        bit in_hold = 1'b0;
        bit flushed = 1'b0;
        if (flush_at == 0 && wen == 4'b0000) begin
            exp_rdata = rdata;
        end
        mem_en     = 1'b1;
        mem_wen    = wen;
        mem_size   = size;
        mem_addr   = addr;
        mem_wdata  = wdata;
        mem_excpt  = 1'b0;
        flush      = 1'b0;
        pipe_stall = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            bus.data_addr_ok = 1'b0;
            bus.data_data_ok = 1'b0;
            flush   = 1'b0;
            in_hold = 1'b0;
            if (flushed) begin
                mem_en = 1'b0;
            end
            if (resp_done) begin
                in_hold    = 1'b1;
                pipe_stall = (hold_n < hold_cyc);
                hold_n++;
                if (!pipe_stall) begin
                    done = 1'b1;
                end
            end else if (bus.data_req) begin
                req_cyc++;
                if (flush_at == 1 && req_cyc == 1) begin
                    flush   = 1'b1;
                    flushed = 1'b1;
                end
                if (req_cyc == a_lat + 1) begin
                    bus.data_addr_ok = 1'b1;
                    addr_done = 1'b1;
                end
            end else if (addr_done) begin
                if (flush_at == 2 && dwait == 0) begin
                    flush   = 1'b1;
                    flushed = 1'b1;
                end
                if (dwait == d_lat) begin
                    bus.data_data_ok = 1'b1;
                    bus.data_rdata   = rdata;
                    resp_done = 1'b1;
                    if (flush_at != 0) begin
                        done = 1'b1;
                    end
                end else begin
                    bus.data_rdata = $urandom;
                end
                dwait++;
            end
            @(negedge clk);
            stall_cyc += int'(dmem_stall);
            if (in_hold) begin
                chk("hold_stall", {31'd0, dmem_stall}, 32'd0);
                chk("hold_rdata", mem_rdata, exp_rdata);
            end
            if (bus.data_req) begin
                chk("bus_wr", {31'd0, bus.data_wr}, {31'd0, (wen != 4'b0000)});
                chk("bus_size", {30'd0, bus.data_size}, {30'd0, size});
                chk("bus_addr", bus.data_addr, addr);
                if (wen != 4'b0000) begin
                    chk("bus_wdata", bus.data_wdata, wdata);
                end
            end
            @(posedge clk);
            #1;
        end
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        flush      = 1'b0;
        pipe_stall = 1'b0;
        chk("completed", {31'd0, done}, 32'd1);
        chk("req_cycles", req_cyc, a_lat + 1);
        chk("stall_cycles", stall_cyc, a_lat + d_lat + 3);
        chk("rdata_after", mem_rdata, exp_rdata);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] w;
        int         fm;
        clk = 1'b0;
        n_pass = 0;
        n_total = 0;
        exp_rdata = 32'd0;
        resetn = 1'b0;
        mem_en = 1'b0;
        mem_wen = 4'd0;
        mem_size = 2'd0;
        mem_addr = 32'd0;
        mem_wdata = 32'd0;
        mem_excpt = 1'b0;
        flush = 1'b0;
        pipe_stall = 1'b0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata = 32'd0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, bus.data_req}, 32'd0);
        chk("rst_wr", {31'd0, bus.data_wr}, 32'd0);
        chk("rst_size", {30'd0, bus.data_size}, 32'd0);
        chk("rst_addr", bus.data_addr, 32'd0);
        chk("rst_wdata", bus.data_wdata, 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);
        chk("rst_stall", {31'd0, dmem_stall}, 32'd0);
        resetn = 1'b1;
        idle_cycle();

        // Load with slow accept and slow data.
        do_access(4'b0000, 2'd2, 32'h8000_0010, 32'd0, 32'hDEAD_BEEF, 1, 2, 0, 0);
        // Word store on a zero-wait bus, back to back with the load.
        do_access(4'b1111, 2'd2, 32'h0000_0040, 32'h1234_5678, 32'h0BAD_0BAD, 0, 0, 0, 0);

        // Excepting instruction and flush in IDLE never reach the bus.
        mem_en = 1'b1;
        mem_wen = 4'b0000;
        mem_excpt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("excpt_req", {31'd0, bus.data_req}, 32'd0);
            chk("excpt_stall", {31'd0, dmem_stall}, 32'd0);
            @(posedge clk);
            #1;
        end
        mem_excpt = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_idle_stall", {31'd0, dmem_stall}, 32'd0);
        @(posedge clk);
        #1;
        idle_cycle();

        // Flushed load: response absorbed, then a fresh load issues.
        do_access(4'b0000, 2'd2, 32'h0000_0200, 32'd0, 32'hAAAA_5555, 0, 1, 0, 2);
        do_access(4'b0000, 2'd1, 32'h0000_0206, 32'd0, 32'h0000_7FFE, 0, 0, 0, 0);
        // Flush while request still pending.
        do_access(4'b0000, 2'd0, 32'h0000_0301, 32'd0, 32'h5A5A_5A5A, 2, 1, 0, 1);
        // Held in HOLD for four cycles.
        do_access(4'b0000, 2'd2, 32'h0000_0400, 32'd0, 32'h0F0F_F0F0, 0, 0, 4, 0);

        // Reset in DATA of a store, then a stray data_ok in IDLE.
        mem_en = 1'b1;
        mem_wen = 4'b1111;
        mem_size = 2'd2;
        mem_addr = 32'h0000_0100;
        mem_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        bus.data_addr_ok = 1'b1;
        @(posedge clk);
        #1;
        bus.data_addr_ok = 1'b0;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        mem_en = 1'b0;
        bus.data_data_ok = 1'b1;
        bus.data_rdata = 32'hFFFF_FFFF;
        exp_rdata = 32'd0;
        @(negedge clk);
        chk("rst2_req", {31'd0, bus.data_req}, 32'd0);
        chk("rst2_wr", {31'd0, bus.data_wr}, 32'd0);
        chk("rst2_size", {30'd0, bus.data_size}, 32'd0);
        chk("rst2_addr", bus.data_addr, 32'd0);
        chk("rst2_wdata", bus.data_wdata, 32'd0);
        chk("rst2_rdata", mem_rdata, 32'd0);
        chk("rst2_stall", {31'd0, dmem_stall}, 32'd0);
        @(posedge clk);
        #1;
        bus.data_data_ok = 1'b0;
        @(negedge clk);
        chk("stray_rdata", mem_rdata, 32'd0);
        chk("stray_stall", {31'd0, dmem_stall}, 32'd0);
        @(posedge clk);
        #1;

        // Randomized accesses.
        for (int n = 0; n < 16; n++) begin
            w  = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            fm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            do_access(w, 2'($urandom_range(0, 2)), $urandom, $urandom, $urandom,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), fm);
            if ($urandom_range(0, 2) == 0) begin
                idle_cycle();
            end
        end
        idle_cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
